// File: rtl/coin_dispenser_if.sv
// Handshake bundle between the vending controller / mechanism drivers and the
// coin dispenser. The master side drives requests and mechanical acks; the
// slave side (the dispenser) drives pulses, status and inventories.
interface coin_dispenser_if #(
    parameter int INV_W = 8
);
    logic [1:0]       change;
    logic             done;
    logic             vend_ack;
    logic             coin_drop;
    logic             refill;
    logic             fault_clr;
    logic             vend_req;
    logic             eject5;
    logic             eject10;
    logic             busy;
    logic             fault;
    logic             short_change;
    logic             overrun;
    logic [INV_W-1:0] cnt5;
    logic [INV_W-1:0] cnt10;

    modport master (
        output change, done, vend_ack, coin_drop, refill, fault_clr,
        input  vend_req, eject5, eject10, busy, fault, short_change, overrun,
               cnt5, cnt10
    );

    modport slave (
        input  change, done, vend_ack, coin_drop, refill, fault_clr,
        output vend_req, eject5, eject10, busy, fault, short_change, overrun,
               cnt5, cnt10
    );
endinterface

// File: rtl/coin_dispenser.sv
// Coin dispenser: turns vend transactions into a product-release pulse followed
// by one-at-a-time coin ejects, tracks hopper inventories, substitutes two 5s
// for a missing 10, and faults when a mechanical ack does not arrive in time.
// Every output is a register; pulses are computed from the current state and
// land one edge after the state that issues them.
module coin_dispenser #(
    parameter int INV_W   = 8,
    parameter int INIT_5  = 20,
    parameter int INIT_10 = 10,
    parameter int TIMEOUT = 15
) (
    input logic              clk,
    input logic              rst,
    coin_dispenser_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, VEND, VEND_WAIT, PICK, EJ_WAIT, FAULT} state_t;

    localparam logic [INV_W-1:0] INIT5_V  = INV_W'(INIT_5);
    localparam logic [INV_W-1:0] INIT10_V = INV_W'(INIT_10);
    // Timer starts at 0 on the pulse edge, so the fault edge is when it already
    // holds TIMEOUT-1.
    localparam logic [7:0]       TMO_LAST = 8'(TIMEOUT - 1);
    localparam logic [INV_W-1:0] ONE      = INV_W'(1);

    state_t           state, state_d;
    logic [7:0]       timer, timer_d;
    logic [1:0]       units, units_d;
    logic             ctype10, ctype10_d;
    logic             pend_valid, pend_valid_d;
    logic             pend_vend, pend_vend_d;
    logic [1:0]       pend_units, pend_units_d;
    logic [INV_W-1:0] cnt5_q, cnt5_d, cnt10_q, cnt10_d;
    logic             short_q, short_d, over_q, over_d;
    logic             vend_req_q, vend_req_d, ej5_q, ej5_d, ej10_q, ej10_d;
    logic             busy_q, busy_d, fault_q, fault_d;

    logic             req;
    logic [1:0]       req_units;
    logic             job_go, job_vend;
    logic [1:0]       job_units;

    // Request decode: 11 on change is treated as no change.
    always_comb begin
        req_units = 2'd0;
        if (bus.change == 2'b01) req_units = 2'd1;
        if (bus.change == 2'b10) req_units = 2'd2;
        req = bus.done | (req_units != 2'd0);
    end

    // Next-state, datapath and registered-output values.
    always_comb begin
        state_d      = state;
        timer_d      = timer;
        units_d      = units;
        ctype10_d    = ctype10;
        pend_valid_d = pend_valid;
        pend_vend_d  = pend_vend;
        pend_units_d = pend_units;
        cnt5_d       = cnt5_q;
        cnt10_d      = cnt10_q;
        short_d      = short_q;
        over_d       = over_q;
        vend_req_d   = 1'b0;
        ej5_d        = 1'b0;
        ej10_d       = 1'b0;
        job_go       = 1'b0;
        job_vend     = 1'b0;
        job_units    = 2'd0;

        case (state)
            IDLE: begin
                // Pending job first; a live request in the same cycle refills the slot.
                if (pend_valid) begin
                    job_go       = 1'b1;
                    job_vend     = pend_vend;
                    job_units    = pend_units;
                    pend_valid_d = req;
                    pend_vend_d  = bus.done;
                    pend_units_d = req_units;
                end else if (req) begin
                    job_go    = 1'b1;
                    job_vend  = bus.done;
                    job_units = req_units;
                end else if (bus.refill) begin
                    cnt5_d  = INIT5_V;
                    cnt10_d = INIT10_V;
                end
                if (job_go) begin
                    units_d = job_units;
                    state_d = job_vend ? VEND : PICK;
                end
            end
            VEND: begin
                vend_req_d = 1'b1;
                timer_d    = 8'd0;
                state_d    = VEND_WAIT;
            end
            VEND_WAIT: begin
                if (bus.vend_ack)          state_d = (units != 2'd0) ? PICK : IDLE;
                else if (timer == TMO_LAST) state_d = FAULT;
                else                        timer_d = timer + 8'd1;
            end
            PICK: begin
                if (units == 2'd0) begin
                    state_d = IDLE;
                end else if (units == 2'd2 && cnt10_q != '0) begin
                    ej10_d    = 1'b1;
                    ctype10_d = 1'b1;
                    timer_d   = 8'd0;
                    state_d   = EJ_WAIT;
                end else if (cnt5_q != '0) begin
                    ej5_d     = 1'b1;
                    ctype10_d = 1'b0;
                    timer_d   = 8'd0;
                    state_d   = EJ_WAIT;
                end else begin
                    short_d = 1'b1;
                    units_d = 2'd0;
                    state_d = IDLE;
                end
            end
            EJ_WAIT: begin
                if (bus.coin_drop) begin
                    if (ctype10) begin
                        if (cnt10_q != '0) cnt10_d = cnt10_q - ONE;
                        units_d = (units >= 2'd2) ? units - 2'd2 : 2'd0;
                    end else begin
                        if (cnt5_q != '0) cnt5_d = cnt5_q - ONE;
                        units_d = (units >= 2'd1) ? units - 2'd1 : 2'd0;
                    end
                    state_d = PICK;
                end else if (timer == TMO_LAST) begin
                    state_d = FAULT;
                end else begin
                    timer_d = timer + 8'd1;
                end
            end
            FAULT: begin
                pend_valid_d = 1'b0;
                units_d      = 2'd0;
                if (req) over_d = 1'b1;
                if (bus.fault_clr) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Requests arriving mid-job are parked in the single slot or lost.
        if (req && state != IDLE && state != FAULT) begin
            if (pend_valid) begin
                over_d = 1'b1;
            end else begin
                pend_valid_d = 1'b1;
                pend_vend_d  = bus.done;
                pend_units_d = req_units;
            end
        end

        busy_d  = (state_d != IDLE);
        fault_d = (state_d == FAULT);
    end

    // State, datapath and output registers; reset aborts any job immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            timer      <= 8'd0;
            units      <= 2'd0;
            ctype10    <= 1'b0;
            pend_valid <= 1'b0;
            pend_vend  <= 1'b0;
            pend_units <= 2'd0;
            cnt5_q     <= INIT5_V;
            cnt10_q    <= INIT10_V;
            short_q    <= 1'b0;
            over_q     <= 1'b0;
            vend_req_q <= 1'b0;
            ej5_q      <= 1'b0;
            ej10_q     <= 1'b0;
            busy_q     <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state      <= state_d;
            timer      <= timer_d;
            units      <= units_d;
            ctype10    <= ctype10_d;
            pend_valid <= pend_valid_d;
            pend_vend  <= pend_vend_d;
            pend_units <= pend_units_d;
            cnt5_q     <= cnt5_d;
            cnt10_q    <= cnt10_d;
            short_q    <= short_d;
            over_q     <= over_d;
            vend_req_q <= vend_req_d;
            ej5_q      <= ej5_d;
            ej10_q     <= ej10_d;
            busy_q     <= busy_d;
            fault_q    <= fault_d;
        end
    end

    assign bus.vend_req     = vend_req_q;
    assign bus.eject5       = ej5_q;
    assign bus.eject10      = ej10_q;
    assign bus.busy         = busy_q;
    assign bus.fault        = fault_q;
    assign bus.short_change = short_q;
    assign bus.overrun      = over_q;
    assign bus.cnt5         = cnt5_q;
    assign bus.cnt10        = cnt10_q;
endmodule
